// File: rtl/kgp_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : kgp_alu_pkg
// Brief   : Shared ALU opcodes, datapath width and multiply-sequencer states.
// Rev     : 1.0
// ============================================================================
package kgp_alu_pkg;

  localparam int ALU_XLEN = 32;

  localparam logic [3:0] ALU_OP_PASS = 4'b0000;
  localparam logic [3:0] ALU_OP_ADD  = 4'b0001;
  localparam logic [3:0] ALU_OP_AND  = 4'b0010;
  localparam logic [3:0] ALU_OP_XOR  = 4'b0011;
  localparam logic [3:0] ALU_OP_NEG  = 4'b0101;
  localparam logic [3:0] ALU_OP_SLL  = 4'b0110;
  localparam logic [3:0] ALU_OP_SRL  = 4'b0111;
  localparam logic [3:0] ALU_OP_SRA  = 4'b1000;

  typedef enum logic [2:0] {
    MUL_IDLE = 3'd0,
    MUL_NEGA = 3'd1,
    MUL_NEGB = 3'd2,
    MUL_LOOP = 3'd3,
    MUL_NEGR = 3'd4,
    MUL_DONE = 3'd5
  } mul_state_e;

endpackage
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module  : alu_mul_seq
// Brief   : Shift-add 32x32 multiplier (low word) that borrows the shared ALU.
//           Optional macro MUL_EARLY_EXIT_EN ends the loop once the multiplier
//           has no set bits left.
// Rev     : 1.0
// ============================================================================
module alu_mul_seq
  import kgp_alu_pkg::*;
#(
  parameter int XLEN  = ALU_XLEN,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_signed,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_prod,
  output logic            out_ovf,
  output logic            busy,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  output logic [4:0]      alu_shamt,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_carry
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  mul_state_e       state_q, state_d;
  logic [XLEN-1:0]  mcand_q, mcand_d;
  logic [XLEN-1:0]  mplr_q, mplr_d;
  logic [XLEN-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_res_q, neg_res_d;
  logic             ovf_q, ovf_d;
  logic             loop_last;

`ifdef MUL_EARLY_EXIT_EN
  assign loop_last = (cnt_q == CNT_LAST) || (mplr_q[XLEN-1:1] == '0);
`else
  assign loop_last = (cnt_q == CNT_LAST);
`endif

  assign in_ready  = (state_q == MUL_IDLE);
  assign busy      = (state_q != MUL_IDLE);
  assign out_valid = (state_q == MUL_DONE);
  assign out_prod  = out_valid ? acc_q : '0;
  assign out_ovf   = out_valid & ovf_q;
  assign alu_shamt = 5'd0;

  always_comb begin
    alu_op = ALU_OP_PASS;
    alu_a  = '0;
    alu_b  = '0;
    case (state_q)
      MUL_NEGA: begin alu_op = ALU_OP_NEG; alu_b = mcand_q; end
      MUL_NEGB: begin alu_op = ALU_OP_NEG; alu_b = mplr_q;  end
      MUL_NEGR: begin alu_op = ALU_OP_NEG; alu_b = acc_q;   end
      MUL_LOOP: begin
        if (mplr_q[0]) begin
          alu_op = ALU_OP_ADD;
          alu_a  = acc_q;
          alu_b  = mcand_q;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_res_d = neg_res_q;
    ovf_d     = ovf_q;
    case (state_q)
      MUL_IDLE: begin
        if (in_valid) begin
          mcand_d   = in_a;
          mplr_d    = in_b;
          acc_d     = '0;
          cnt_d     = '0;
          ovf_d     = 1'b0;
          neg_res_d = in_signed & (in_a[XLEN-1] ^ in_b[XLEN-1]);
          if (in_signed && in_a[XLEN-1])      state_d = MUL_NEGA;
          else if (in_signed && in_b[XLEN-1]) state_d = MUL_NEGB;
          else                                state_d = MUL_LOOP;
        end
      end
      MUL_NEGA: begin
        mcand_d = alu_result;
        // a is negative here, so b is negative exactly when the signs agree
        state_d = neg_res_q ? MUL_LOOP : MUL_NEGB;
      end
      MUL_NEGB: begin
        mplr_d  = alu_result;
        state_d = MUL_LOOP;
      end
      MUL_LOOP: begin
        if (mplr_q[0]) begin
          acc_d = alu_result;
          ovf_d = ovf_q | alu_carry;
        end
        // a set top bit is about to be shifted out while multiplier bits remain
        if (mcand_q[XLEN-1] && (mplr_q[XLEN-1:1] != '0)) ovf_d = 1'b1;
        mcand_d = {mcand_q[XLEN-2:0], 1'b0};
        mplr_d  = {1'b0, mplr_q[XLEN-1:1]};
        cnt_d   = cnt_q + CNT_W'(1);
        if (loop_last) state_d = neg_res_q ? MUL_NEGR : MUL_DONE;
      end
      MUL_NEGR: begin
        acc_d   = alu_result;
        state_d = MUL_DONE;
      end
      MUL_DONE: begin
        if (out_ready) state_d = MUL_IDLE;
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= MUL_IDLE;
      mcand_q   <= '0;
      mplr_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_mul_seq
// Brief   : Directed self-checking bench for alu_mul_seq with a behavioural ALU.
// Rev     : 1.0
// ============================================================================
module tb_alu_mul_seq;

`ifdef MUL_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_signed = 1'b0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_prod;
  logic        out_ovf;
  logic        busy;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_result;
  logic        alu_carry;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_mul_seq dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_prod(out_prod), .out_ovf(out_ovf), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_shamt(alu_shamt),
    .alu_result(alu_result), .alu_carry(alu_carry)
  );

  // behavioural model of the shared ALU (only the ops this block uses)
  always_comb begin
    logic [32:0] sum;
    sum        = '0;
    alu_result = alu_a;
    alu_carry  = 1'b0;
    case (alu_op)
      4'b0001: begin sum = {1'b0, alu_a} + {1'b0, alu_b}; alu_result = sum[31:0]; alu_carry = sum[32]; end
      4'b0101: begin sum = {1'b0, ~alu_b} + 33'd1; alu_result = sum[31:0]; alu_carry = sum[32]; end
      default: ;
    endcase
  end

  function automatic int lat_sel(input int full, input int early);
    return EARLY ? early : full;
  endfunction

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL handshake: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic run_mul(input string nm, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ep, input logic eo, input int elat, input int eadds);
    int lat;
    int adds;
    @(negedge clk);
    in_signed = sgn; in_a = a; in_b = b; in_valid = 1'b1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s ready: in_ready=%b want 1", nm, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    adds = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      if (alu_op === 4'b0001) adds++;
      @(posedge clk); #1;
      lat++;
    end
    vectors++;
    if (lat !== elat) begin
      miscompares++;
      $display("FAIL %s latency: got %0d want %0d", nm, lat, elat);
    end
    vectors++;
    if (out_prod !== ep || out_ovf !== eo) begin
      miscompares++;
      $display("FAIL %s result: prod=%h ovf=%b want prod=%h ovf=%b", nm, out_prod, out_ovf, ep, eo);
    end
    vectors++;
    if (adds !== eadds) begin
      miscompares++;
      $display("FAIL %s add_cycles: got %0d want %0d", nm, adds, eadds);
    end
    handshake();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_prod !== 32'd0 || out_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: rdy=%b vld=%b busy=%b prod=%h ovf=%b want 1/0/0/0/0",
               in_ready, out_valid, busy, out_prod, out_ovf);
    end
    vectors++;
    if (alu_op !== 4'b0000 || alu_a !== 32'd0 || alu_b !== 32'd0 || alu_shamt !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_alu: op=%h a=%h b=%h shamt=%h want all 0", alu_op, alu_a, alu_b, alu_shamt);
    end
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    run_mul("u7x6",    1'b0, 32'd7, 32'd6, 32'd42, 1'b0, lat_sel(33, 4), 2);
    run_mul("u2x3",    1'b0, 32'd2, 32'd3, 32'd6,  1'b0, lat_sel(33, 3), 2);
    run_mul("u5x0",    1'b0, 32'd5, 32'd0, 32'd0,  1'b0, lat_sel(33, 2), 0);
    run_mul("uff_ff",  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 33, 32);
    run_mul("u64k2",   1'b0, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1, lat_sel(33, 18), 1);
    run_mul("u2g_x2",  1'b0, 32'h8000_0000, 32'd2, 32'd0, 1'b1, lat_sel(33, 3), 1);
  endtask

  task automatic test_signed();
    run_mul("s-3x5",   1'b1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 1'b0, lat_sel(35, 6), 2);
    run_mul("s-4x-4",  1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'd16, 1'b0, lat_sel(35, 6), 1);
    run_mul("s-1x-1",  1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, lat_sel(35, 4), 1);
    run_mul("sminx1",  1'b1, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, lat_sel(35, 4), 1);
    run_mul("s5x0",    1'b1, 32'd5, 32'd0, 32'd0, 1'b0, lat_sel(33, 2), 0);
  endtask

  task automatic test_hold_in_done();
    int waited;
    @(negedge clk);
    in_signed = 1'b0; in_a = 32'd3; in_b = 32'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    waited = 0;
    while (out_valid !== 1'b1 && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = 32'd9; in_b = 32'd9;
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b1 || out_prod !== 32'd12 || out_ovf !== 1'b0 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL hold%0d: vld=%b prod=%h ovf=%b rdy=%b want 1/0000000c/0/0",
                 i, out_valid, out_prod, out_ovf, in_ready);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    handshake();
    run_mul("after_hold", 1'b0, 32'd7, 32'd7, 32'd49, 1'b0, lat_sel(33, 4), 3);
  endtask

  task automatic test_reset_midflight();
    bit seen_valid;
    @(negedge clk);
    in_signed = 1'b0; in_a = 32'd100; in_b = 32'd100; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    vectors++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || alu_op !== 4'b0000) begin
      miscompares++;
      $display("FAIL async_rst: busy=%b rdy=%b vld=%b op=%h want 0/1/0/0", busy, in_ready, out_valid, alu_op);
    end
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen_valid = 1'b1;
    end
    vectors++;
    if (seen_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL dropped_req: out_valid seen=%b want 0", seen_valid);
    end
    run_mul("post_rst3x3", 1'b0, 32'd3, 32'd3, 32'd9, 1'b0, lat_sel(33, 3), 2);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_hold_in_done();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
